uart_io_ctrl: RTL
=================

// Module: uart_io_ctrl
// PURPOSE
//  Sits between the UART receiver/sender and the core. Schedules the single
//  UART byte stream in both directions. In LOAD mode, received bytes go to the
//  program loader. In EXEC mode, they are buffered in an RX FIFO for IN
//  instructions. OUT bytes are queued in a TX FIFO, so the core stalls only
//  when that FIFO is full.
// PARAMETERS
//  RX_DEPTH_LOG2  4  log2 of RX FIFO entries (16)
//  TX_DEPTH_LOG2  4  log2 of TX FIFO entries (16)
// PORTS
//  CLK           in   1  system clock; the only clock
//  RST           in   1  synchronous, active-high reset
//  mode_load     in   1  1 = LOAD mode (program download), 0 = EXEC mode
//  rx_data       in   8  byte from receiver
//  rx_valid      in   1  one-cycle pulse from receiver; no backpressure possible
//  tx_data       out  8  byte to sender
//  tx_valid      out  1  tx_data holds a byte for the sender
//  tx_ready      in   1  sender idle; byte transferred when tx_valid&&tx_ready
//  load_data     out  8  received byte, routed to the loader
//  load_valid    out  1  one-cycle pulse per loader byte
//  in_req        in   1  core is executing IN
//  in_data       out  8  RX FIFO head
//  in_ack        out  1  in_data valid this cycle; pops the head
//  out_req       in   1  core is executing OUT
//  out_data      in   8  byte to send
//  out_ack       out  1  out_data accepted this cycle; core may advance pc
//  rx_overflow   out  1  sticky: a received byte was dropped
// BEHAVIOUR
//  - Reset: both FIFOs empty; outputs tx_valid, load_valid, in_ack, out_ack
//    and rx_overflow are 0; load_data/tx_data/in_data are 8'h00. RST
//    mid-operation discards all queued bytes. A frame already inside the
//    sender is not affected.
//  - LOAD path: if mode_load && rx_valid in cycle N, then load_valid=1 and
//    load_data=rx_data in cycle N+1, as a registered pulse. No FIFO is used.
//  - While mode_load=1: the RX FIFO is held empty (cleared every cycle) and
//    in_ack=0.
//  - RX push: on !mode_load && rx_valid. The byte is visible at the head in
//    the next cycle. There is no same-cycle bypass.
//  - RX pop: in_ack = in_req && !rx_empty && !mode_load (combinational). The
//    pop happens at the clock edge.
//  - RX full:
//    - push with a pop in the same cycle: both occur and the count is
//      unchanged.
//    - push without a pop: the byte is dropped, rx_overflow<=1, and it stays
//      set until RST.
//  - TX push: out_ack = out_req && !tx_full (combinational). It ignores a
//    same-cycle tx pop. When out_ack=1, out_data is written at the edge.
//  - TX pop: tx_valid = !tx_empty; tx_data = head. On tx_valid&&tx_ready the
//    head advances. tx_data is stable while tx_valid&&!tx_ready.
//  - TX draining continues in both modes. The mode switch does not flush the
//    TX FIFO.
//  - Empty TX with a push: tx_valid is first 1 the cycle after the push
//    (1-cycle latency).
//  - Pointers are DEPTH_LOG2 bits and wrap modulo the depth. The count is
//    DEPTH_LOG2+1 bits. full = count==2**DEPTH_LOG2; empty = count==0.
//  - Simultaneous push and pop on an empty FIFO: the push succeeds; the pop is
//    not acked because empty=1.
// STRUCTURE
//  - io_pkg holds UART_BYTE_W=8 and the default depth localparams, shared with
//    the loader and the core.
//  - Sub-module byte_fifo #(DEPTH_LOG2) contains the storage, pointers, count,
//    full and empty. It exposes push/pop/clear. It is instantiated twice (rx,
//    tx).
//  - Top level: LOAD routing register, ack logic and the overflow flag.
// TESTING
//  - RST; mode_load=0, tx_ready=1; out_req with 41,42,43 on 3 cycles
//    -> out_ack=1 each cycle; tx_data 41,42,43 transferred on 3 consecutive
//    cycles, starting 1 cycle after the first push.
//  - tx_ready=0; out_req held for 17 bytes 00..10
//    -> out_ack on the first 16 only; the 17th waits. Then tx_ready=1 ->
//    00 transfers, and in the next cycle the 17th byte (10) gets out_ack=1.
//  - in_req=0; rx_valid pulses 12 then 34; later in_req=1 for 3 cycles
//    -> in_data=12 with in_ack=1, then 34 with in_ack=1, then in_ack=0.
//  - 17 rx_valid pulses with no pops -> 16 bytes kept and rx_overflow=1.
//    Then, at full, rx_valid with in_req=1 -> head popped, new byte kept,
//    count stays 16.
//  - mode_load=1; rx_valid with AB -> load_valid=1 and load_data=AB in the
//    next cycle only. The RX FIFO stays empty and in_ack=0 even with in_req=1.
//  - 5 bytes in the TX FIFO and 3 in the RX FIFO; assert RST for 1 cycle
//    -> next cycle tx_valid=0, in_ack=0, rx_overflow=0, and no further tx
//    transfer.

Source files
------------

// File: rtl/io_pkg.sv
// Shared UART byte-stream constants and types, also used by the program
// loader and the core.
package io_pkg;
  localparam int UART_BYTE_W          = 8;
  localparam int RX_DEPTH_LOG2_DEFAULT = 4;
  localparam int TX_DEPTH_LOG2_DEFAULT = 4;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;
endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with a first-word-fall-through head. Pointers wrap modulo the
// depth, and a separate count register tells a full FIFO from an empty one.
module byte_fifo
  import io_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  uart_byte_t data_i,
  output uart_byte_t data_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  uart_byte_t            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty_o = (count_q == '0);

  // When the FIFO is full, a push is accepted only if the same cycle also
  // pops. The write then reuses the slot being vacated.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Present zero when empty so the head never exposes a stale byte.
  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/uart_io_ctrl.sv
// Schedules the single UART byte stream between the loader (LOAD mode), the
// IN/OUT instructions of the core (EXEC mode) and the UART sender.
module uart_io_ctrl
  import io_pkg::*;
#(
  parameter int RX_DEPTH_LOG2 = RX_DEPTH_LOG2_DEFAULT,
  parameter int TX_DEPTH_LOG2 = TX_DEPTH_LOG2_DEFAULT
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   mode_load,
  input  logic [UART_BYTE_W-1:0] rx_data,
  input  logic                   rx_valid,
  output logic [UART_BYTE_W-1:0] tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [UART_BYTE_W-1:0] load_data,
  output logic                   load_valid,
  input  logic                   in_req,
  output logic [UART_BYTE_W-1:0] in_data,
  output logic                   in_ack,
  input  logic                   out_req,
  input  logic [UART_BYTE_W-1:0] out_data,
  output logic                   out_ack,
  output logic                   rx_overflow
);
  logic       rx_push, rx_full, rx_empty;
  logic       tx_full, tx_empty, tx_pop;
  logic       load_valid_q, load_valid_d;
  uart_byte_t load_data_q, load_data_d;
  logic       overflow_q, overflow_d;

  assign rx_push = rx_valid && !mode_load;
  assign in_ack  = in_req && !rx_empty && !mode_load;

  // The RX FIFO is cleared every LOAD-mode cycle, so no stale program bytes
  // are left for IN once execution starts.
  byte_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clear_i (mode_load),
    .push_i  (rx_push),
    .pop_i   (in_ack),
    .data_i  (rx_data),
    .data_o  (in_data),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  // out_ack looks only at the current fill level. A pop in the same cycle
  // frees a slot for the next cycle, not for this one.
  assign out_ack  = out_req && !tx_full;
  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;

  byte_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clear_i (1'b0),
    .push_i  (out_ack),
    .pop_i   (tx_pop),
    .data_i  (out_data),
    .data_o  (tx_data),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  always_comb begin
    load_valid_d = rx_valid && mode_load;
    load_data_d  = load_valid_d ? rx_data : load_data_q;
    overflow_d   = overflow_q || (rx_push && rx_full && !in_ack);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      load_valid_q <= load_valid_d;
      load_data_q  <= load_data_d;
      overflow_q   <= overflow_d;
    end
  end

  assign load_valid  = load_valid_q;
  assign load_data   = load_data_q;
  assign rx_overflow = overflow_q;
endmodule
